ruleid_capture: RTL and testbench
=================================

RULEID_CAPTURE -- requirements
Module: ruleid_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 512: capture word width, multiple of 32, at least 32.
REQ-002 SHALL have parameter DEPTH, default 512: capture memory depth in words, power of 2; ADDR_W = log2(DEPTH).
REQ-003 SHALL have parameter SEL_ID, default 0: block-select value matched against status_addr[29:30-STAT_AWIDTH].
REQ-004 SHALL have port clk  in  1: single clock for all logic; one clock, no second status clock.
REQ-005 SHALL have port rst_n  in  1: reset, synchronous, active-low.
REQ-006 SHALL have port in_data  in  DATA_W: stream word.
REQ-007 SHALL have port in_valid  in  1: in_data qualifier.
REQ-008 SHALL have port in_ready  out  1: constant 1; the block never stalls.
REQ-009 SHALL have ports status_addr in 30, status_read in 1, status_write in 1, status_writedata in 32: status bus request.
REQ-010 SHALL have ports status_readdata out 32, status_readdata_valid out 1: status bus read response.

Function
REQ-011 SHALL derive SW = log2(DATA_W/32) and SHALL require SW+ADDR_W <= 15 (elaboration error otherwise).
REQ-012 SHALL decode only accesses where the select field equals SEL_ID; a non-matching access SHALL produce no response and no side effect.
REQ-013 SHALL decode status_addr[15]=1 as a memory read: word = status_addr[SW+ADDR_W-1:SW], slice = status_addr[SW-1:0], slice 0 = bits [31:0].
REQ-014 SHALL decode status_addr[15]=0 as register space via status_addr[3:0]: 0 CTRL (RW), 1 STATUS (RO), 2 WR_PTR (RO), 3 COUNT (RO), 4 DROP (RO), 5 START_TS (RO), 6 STOP_TS (RO); other offsets SHALL read 0.
REQ-015 SHALL implement CTRL bit0 ARM, bit1 WRAP, bit2 CLEAR (self-clearing, reads 0); writes to RO offsets and to memory space SHALL be ignored.
REQ-016 SHALL return read data with status_readdata_valid high for exactly one cycle, 3 cycles after status_read (issued N, valid N+3), one response per read, including back-to-back reads.
REQ-017 SHALL hold status_readdata between responses.
REQ-018 SHALL implement states IDLE, CAPTURE, DONE; STATUS[1:0] = 0/1/2 respectively, STATUS[2] = WRAPPED, STATUS[3] = FULL.
REQ-019 SHALL move IDLE->CAPTURE on a CTRL write with ARM=1, taking effect the cycle after the write; the WRAP mode SHALL be latched at the same time.
REQ-020 SHALL register in_data/in_valid once; a beat valid at cycle N in CAPTURE SHALL be written to memory[WR_PTR] at N+1, with WR_PTR and COUNT incremented.
REQ-021 In one-shot mode (WRAP=0), the write to address DEPTH-1 SHALL set FULL and move to DONE; WR_PTR SHALL read DEPTH-1 afterwards (no wrap).
REQ-022 In wrap mode (WRAP=1), WR_PTR SHALL roll DEPTH-1 -> 0, set WRAPPED, and stay in CAPTURE.
REQ-023 A CTRL write with ARM=0 in CAPTURE SHALL move to DONE; beats already registered SHALL still be written.
REQ-024 A CTRL write with ARM=1 in DONE SHALL be ignored; only CLEAR SHALL leave DONE.
REQ-025 CLEAR SHALL force IDLE and zero WR_PTR, COUNT, DROP, WRAPPED, FULL; CLEAR SHALL take priority over ARM in the same write.
REQ-026 COUNT SHALL be 32-bit, saturating at 0xFFFFFFFF, counting all beats written including wrapped overwrites.
REQ-027 DROP SHALL be 32-bit saturating and count in_valid beats arriving when not in CAPTURE, including the cycle of the arming write.
REQ-028 A memory read of the word being written in the same cycle SHALL return the old data (read-before-write).
REQ-029 Memory contents SHALL NOT be cleared by reset or CLEAR.

Reset
REQ-030 While rst_n=0 at a clk edge: state IDLE, CTRL=0, WR_PTR=0, COUNT=0, DROP=0, flags 0, status_readdata=0, status_readdata_valid=0, pipeline valids 0.
REQ-031 Reset mid-capture or mid-read SHALL abort it; a pending read SHALL NOT produce a response.

Configuration
REQ-032 With RULEID_CAPTURE_TSTAMP_EN defined: a free-running 32-bit cycle counter (reset 0, wrapping) SHALL exist; START_TS SHALL latch it on IDLE->CAPTURE and STOP_TS on entry to DONE; CLEAR SHALL zero both.
REQ-033 Without RULEID_CAPTURE_TSTAMP_EN: no counter is built; START_TS and STOP_TS SHALL read 0.

Verification
REQ-034 DEPTH=8, one-shot, arm, 10 consecutive beats -> FULL=1, state DONE, COUNT=8, DROP=2, memory words 0..7 = beats 0..7.
REQ-035 DEPTH=8, wrap, 11 beats -> WRAPPED=1, WR_PTR=3, COUNT=11, words 0..2 = beats 8..10, words 3..7 = beats 3..7.
REQ-036 Read of address 0x8000|(word 2<<4)|slice 15 at cycle N (DATA_W=512) -> valid at N+3 only, data = beat2[511:480].
REQ-037 CTRL write 0x5 (CLEAR+ARM) in CAPTURE -> state IDLE, COUNT=0, DROP=0, no capture.
REQ-038 rst_n low for 1 cycle between a read and its response -> no status_readdata_valid pulse; all registers read as reset values.
REQ-039 Macro defined: arm at cycle 100, stop at 150 -> START_TS=101, STOP_TS=151; macro undefined -> both read 0.

Source files
------------

// File: rtl/ruleid_capture.sv
// rtl/ruleid_capture.sv - armed stream capture memory with status-bus register and memory readback
// Define RULEID_CAPTURE_TSTAMP_EN to build the start/stop cycle timestamps.
module ruleid_capture #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 512,
  parameter int SEL_ID = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [29:0]       status_addr,
  input  logic              status_read,
  input  logic              status_write,
  input  logic [31:0]       status_writedata,
  output logic [31:0]       status_readdata,
  output logic              status_readdata_valid
);
  localparam int NW          = DATA_W / 32;
  localparam int SW          = $clog2(NW);
  localparam int SW_E        = (SW > 0) ? SW : 1;
  localparam int ADDR_W      = $clog2(DEPTH);
  localparam int STAT_AWIDTH = 14;
  localparam logic [STAT_AWIDTH-1:0] SEL  = STAT_AWIDTH'(SEL_ID);
  localparam logic [ADDR_W-1:0]      LAST = ADDR_W'(DEPTH - 1);

  if (SW + ADDR_W > 15) begin : g_cfg_check
    $error("ruleid_capture: word and slice fields do not fit below status_addr[15]");
  end

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CAPTURE = 2'd1, ST_DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic                wrap_mode_q, wrap_mode_d, wrapped_q, wrapped_d, full_q, full_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]         count_q, count_d, drop_q, drop_d;
  logic [NW-1:0][31:0] beat_q, beat_d;
  logic                beat_valid_q, beat_valid_d;
  logic [NW-1:0][31:0] mem [DEPTH];
  logic [NW-1:0][31:0] mem_rdata_q;

  logic                rq_valid_q, rq_valid_d, rq_mem_q, rq_mem_d;
  logic [ADDR_W-1:0]   rq_word_q, rq_word_d;
  logic [SW_E-1:0]     rq_slice_q, rq_slice_d, rd_slice_q, rd_slice_d;
  logic [3:0]          rq_off_q, rq_off_d;
  logic                rd_valid_q, rd_valid_d, rd_mem_q, rd_mem_d;
  logic [31:0]         rd_reg_q, rd_reg_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;

  logic                sel_match, ctrl_wr, do_clear, wr_en, lost, arrive_drop;
  logic [32:0]         drop_sum;
  logic [31:0]         start_ts, stop_ts;
  logic                unused_bits;

  assign in_ready              = 1'b1;
  assign status_readdata       = rsp_data_q;
  assign status_readdata_valid = rsp_valid_q;
  assign unused_bits           = ^{status_writedata[31:3], status_addr[14:4]};

  always_comb begin
    sel_match   = (status_addr[29:30-STAT_AWIDTH] == SEL);
    ctrl_wr     = status_write && sel_match && !status_addr[15] && (status_addr[3:0] == 4'd0);
    do_clear    = ctrl_wr && status_writedata[2];
    // A registered beat is committed unless the one-shot buffer filled or a CLEAR intervened.
    wr_en       = beat_valid_q && !full_q && (state_q != ST_IDLE);
    lost        = beat_valid_q && !wr_en;
    arrive_drop = in_valid && (state_q != ST_CAPTURE);

    state_d      = state_q;
    ctrl_d       = ctrl_q;
    wrap_mode_d  = wrap_mode_q;
    wrapped_d    = wrapped_q;
    full_d       = full_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    beat_d       = in_data;
    beat_valid_d = in_valid && (state_q == ST_CAPTURE);
    drop_sum     = {1'b0, drop_q} + 33'(arrive_drop) + 33'(lost);
    drop_d       = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];

    if (wr_en) begin
      if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
      if (wr_ptr_q == LAST) begin
        if (wrap_mode_q) begin
          wr_ptr_d  = '0;
          wrapped_d = 1'b1;
        end else begin
          full_d  = 1'b1;
          state_d = ST_DONE;
        end
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (ctrl_wr) begin
      ctrl_d = status_writedata[1:0];
      if (do_clear) begin
        state_d      = ST_IDLE;
        wr_ptr_d     = '0;
        count_d      = '0;
        drop_d       = '0;
        wrapped_d    = 1'b0;
        full_d       = 1'b0;
        beat_valid_d = 1'b0;
      end else if (state_q == ST_IDLE && status_writedata[0]) begin
        state_d     = ST_CAPTURE;
        wrap_mode_d = status_writedata[1];
      end else if (state_q == ST_CAPTURE && !status_writedata[0]) begin
        state_d = ST_DONE;
      end
    end
  end

`ifdef RULEID_CAPTURE_TSTAMP_EN
  logic [31:0] ts_q, ts_d, start_ts_q, start_ts_d, stop_ts_q, stop_ts_d;

  // Stamps hold the counter value of the first cycle spent in the new state.
  always_comb begin
    ts_d       = ts_q + 32'd1;
    start_ts_d = start_ts_q;
    stop_ts_d  = stop_ts_q;
    if (state_q == ST_IDLE && state_d == ST_CAPTURE) start_ts_d = ts_d;
    if (state_q != ST_DONE && state_d == ST_DONE) stop_ts_d = ts_d;
    if (do_clear) begin
      start_ts_d = '0;
      stop_ts_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q       <= '0;
      start_ts_q <= '0;
      stop_ts_q  <= '0;
    end else begin
      ts_q       <= ts_d;
      start_ts_q <= start_ts_d;
      stop_ts_q  <= stop_ts_d;
    end
  end

  assign start_ts = start_ts_q;
  assign stop_ts  = stop_ts_q;
`else
  assign start_ts = '0;
  assign stop_ts  = '0;
`endif

  // Read pipeline: request latch, memory/register fetch, slice select.
  always_comb begin
    rq_valid_d = status_read && sel_match;
    rq_mem_d   = status_addr[15];
    rq_word_d  = status_addr[SW+ADDR_W-1:SW];
    rq_slice_d = (SW > 0) ? status_addr[SW_E-1:0] : '0;
    rq_off_d   = status_addr[3:0];
    rd_valid_d = rq_valid_q;
    rd_mem_d   = rq_mem_q;
    rd_slice_d = rq_slice_q;
    rd_reg_d   = '0;
    case (rq_off_q)
      4'd0:    rd_reg_d = {30'd0, ctrl_q};
      4'd1:    rd_reg_d = {28'd0, full_q, wrapped_q, state_q};
      4'd2:    rd_reg_d = 32'(wr_ptr_q);
      4'd3:    rd_reg_d = count_q;
      4'd4:    rd_reg_d = drop_q;
      4'd5:    rd_reg_d = start_ts;
      4'd6:    rd_reg_d = stop_ts;
      default: rd_reg_d = '0;
    endcase
    rsp_valid_d = rd_valid_q;
    rsp_data_d  = rsp_data_q;
    if (rd_valid_q) rsp_data_d = rd_mem_q ? mem_rdata_q[rd_slice_q] : rd_reg_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= beat_q;
    mem_rdata_q <= mem[rq_word_q];
    beat_q      <= beat_d;
    rq_mem_q    <= rq_mem_d;
    rq_word_q   <= rq_word_d;
    rq_slice_q  <= rq_slice_d;
    rq_off_q    <= rq_off_d;
    rd_mem_q    <= rd_mem_d;
    rd_slice_q  <= rd_slice_d;
    rd_reg_q    <= rd_reg_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= '0;
      wrap_mode_q  <= 1'b0;
      wrapped_q    <= 1'b0;
      full_q       <= 1'b0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      drop_q       <= '0;
      beat_valid_q <= 1'b0;
      rq_valid_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      wrap_mode_q  <= wrap_mode_d;
      wrapped_q    <= wrapped_d;
      full_q       <= full_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
      beat_valid_q <= beat_valid_d;
      rq_valid_q   <= rq_valid_d;
      rd_valid_q   <= rd_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end
endmodule

// File: tb/tb_ruleid_capture.sv
// tb/tb_ruleid_capture.sv - self-checking bench for ruleid_capture with a transaction-level capture model
module tb_ruleid_capture;
  localparam int DW    = 512;
  localparam int NW    = DW / 32;
  localparam int DEPTH = 8;
  localparam int SEL   = 5;
  localparam logic [29:0] BASE  = 30'(SEL) << 16;
  localparam logic [29:0] OTHER = 30'(SEL + 1) << 16;

  logic          clk, rst_n, in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [29:0]   status_addr;
  logic          status_read, status_write, status_readdata_valid;
  logic [31:0]   status_writedata, status_readdata;

  ruleid_capture #(.DATA_W(DW), .DEPTH(DEPTH), .SEL_ID(SEL)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .status_addr(status_addr), .status_read(status_read), .status_write(status_write),
    .status_writedata(status_writedata), .status_readdata(status_readdata),
    .status_readdata_valid(status_readdata_valid)
  );

  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int total, bad;
  logic [NW-1:0][31:0] mem_m [DEPTH];
  bit                  mem_known [DEPTH];
  logic [NW-1:0][31:0] beats [$];
  int exp_count, exp_drop, exp_ptr;
  logic exp_full, exp_wrapped;

  function automatic logic [29:0] mem_addr(input int w, input int s);
    return BASE | 30'h8000 | (30'(w) << 4) | 30'(s);
  endfunction

  function automatic logic [NW-1:0][31:0] rand_beat();
    logic [NW-1:0][31:0] r;
    for (int i = 0; i < NW; i++) r[i] = $urandom;
    return r;
  endfunction

  // Capture rules: one-shot keeps the first DEPTH beats and drops the rest; wrap keeps all, slot i%DEPTH.
  task automatic model_capture(input bit wrap);
    int n;
    n = beats.size();
    exp_count = 0; exp_drop = 0;
    for (int i = 0; i < n; i++) begin
      if (!wrap && i >= DEPTH) exp_drop++;
      else begin
        mem_m[i % DEPTH] = beats[i];
        mem_known[i % DEPTH] = 1;
        exp_count++;
      end
    end
    exp_wrapped = wrap && n >= DEPTH;
    exp_full    = !wrap && n >= DEPTH;
    exp_ptr     = wrap ? n % DEPTH : (exp_full ? DEPTH - 1 : n);
  endtask

  task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    status_addr = a; status_writedata = d; status_write = 1;
    @(negedge clk);
    status_write = 0;
  endtask

  task automatic bus_read(input logic [29:0] a, output logic [31:0] d, output int lat, output int np);
    d = 'x; lat = 0; np = 0;
    @(negedge clk);
    status_addr = a; status_read = 1;
    @(negedge clk);
    status_read = 0;
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
      if (status_readdata_valid) begin
        np++;
        if (lat == 0) begin lat = k; d = status_readdata; end
      end
    end
  endtask

  task automatic send_beats(input int n);
    logic [NW-1:0][31:0] b;
    for (int i = 0; i < n; i++) begin
      b = rand_beat();
      @(negedge clk);
      in_valid = 1; in_data = b;
      beats.push_back(b);
    end
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d; int lat, np;
    total++;
    if (in_ready !== 1'b1 || status_readdata_valid !== 1'b0 || status_readdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b valid=%b data=%h want 1 0 0", in_ready, status_readdata_valid, status_readdata);
    end
    for (int off = 0; off < 10; off++) begin
      bus_read(BASE | 30'(off), d, lat, np);
      total++;
      if (d !== 32'd0) begin bad++; $display("FAIL reset_reg%0d: got %h want 0", off, d); end
    end
  endtask

  task automatic test_select();
    logic [31:0] d; int lat, np;
    bus_write(OTHER, 32'h1);
    bus_read(OTHER | 30'h1, d, lat, np);
    total++;
    if (np !== 0) begin bad++; $display("FAIL foreign_read: got %0d pulses want 0", np); end
    bus_read(BASE | 30'h1, d, lat, np);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL foreign_write: got status %h want 0", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d; int lat, np, s;
    logic [31:0] exp_r [5];
    bus_write(BASE, 32'h4);
    beats.delete();
    bus_write(BASE, 32'h1);
    send_beats(10);
    model_capture(0);
    exp_r = '{32'h1, {28'd0, exp_full, exp_wrapped, 2'd2}, 32'(exp_ptr), 32'(exp_count), 32'(exp_drop)};
    for (int off = 0; off < 5; off++) begin
      bus_read(BASE | 30'(off), d, lat, np);
      total++;
      if (d !== exp_r[off]) begin bad++; $display("FAIL oneshot_reg%0d: got %h want %h", off, d, exp_r[off]); end
    end
    for (int w = 0; w < DEPTH; w++) begin
      s = $urandom_range(0, NW - 1);
      bus_read(mem_addr(w, s), d, lat, np);
      total++;
      if (d !== mem_m[w][s]) begin bad++; $display("FAIL oneshot_mem w%0d s%0d: got %h want %h", w, s, d, mem_m[w][s]); end
    end
  endtask

  task automatic test_read_latency();
    logic [31:0] d; int lat, np;
    bus_read(mem_addr(2, 15), d, lat, np);
    total++;
    if (lat !== 3 || np !== 1) begin bad++; $display("FAIL read_latency: got lat=%0d pulses=%0d want 3 1", lat, np); end
    total++;
    if (d !== mem_m[2][15]) begin bad++; $display("FAIL read_slice15: got %h want %h", d, mem_m[2][15]); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (status_readdata !== mem_m[2][15]) begin bad++; $display("FAIL read_hold: got %h want %h", status_readdata, mem_m[2][15]); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; int lat, np;
    logic [31:0] exp_r [5];
    bus_write(BASE, 32'h4);
    beats.delete();
    bus_write(BASE, 32'h3);
    send_beats(11);
    model_capture(1);
    exp_r = '{32'h3, {28'd0, exp_full, exp_wrapped, 2'd1}, 32'(exp_ptr), 32'(exp_count), 32'(exp_drop)};
    for (int off = 0; off < 5; off++) begin
      bus_read(BASE | 30'(off), d, lat, np);
      total++;
      if (d !== exp_r[off]) begin bad++; $display("FAIL wrap_reg%0d: got %h want %h", off, d, exp_r[off]); end
    end
    for (int w = 0; w < DEPTH; w++) begin
      bus_read(mem_addr(w, w), d, lat, np);
      total++;
      if (d !== mem_m[w][w]) begin bad++; $display("FAIL wrap_mem w%0d: got %h want %h", w, d, mem_m[w][w]); end
    end
    bus_write(BASE, 32'h2);
  endtask

  task automatic test_back_to_back();
    logic        vld [10];
    logic [31:0] dat [10];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 4) begin status_addr = mem_addr(c, 0); status_read = 1; end
      else status_read = 0;
      @(posedge clk); #1;
      vld[c] = status_readdata_valid;
      dat[c] = status_readdata;
    end
    for (int c = 0; c < 10; c++) begin
      total++;
      if (vld[c] !== (c >= 2 && c <= 5)) begin bad++; $display("FAIL b2b_valid c%0d: got %b", c, vld[c]); end
      else if (vld[c] && dat[c] !== mem_m[c-2][0]) begin
        bad++; $display("FAIL b2b_data c%0d: got %h want %h", c, dat[c], mem_m[c-2][0]);
      end
    end
  endtask

  task automatic test_ro_writes();
    logic [31:0] d; int lat, np;
    bus_write(BASE | 30'h3, 32'h1234);
    bus_write(mem_addr(1, 0), 32'hA5A5_5A5A);
    bus_write(BASE | 30'h1, 32'h0);
    bus_read(BASE | 30'h3, d, lat, np);
    total++;
    if (d !== 32'd11) begin bad++; $display("FAIL ro_count: got %h want %h", d, 32'd11); end
    bus_read(mem_addr(1, 0), d, lat, np);
    total++;
    if (d !== mem_m[1][0]) begin bad++; $display("FAIL ro_mem: got %h want %h", d, mem_m[1][0]); end
    bus_read(BASE | 30'h1, d, lat, np);
    total++;
    if (d !== 32'h6) begin bad++; $display("FAIL ro_status: got %h want 6", d); end
  endtask

  task automatic test_arm_drop();
    logic [31:0] d; int lat, np;
    logic [NW-1:0][31:0] b;
    logic [31:0] exp_r [5];
    bus_write(BASE, 32'h4);
    beats.delete();
    b = rand_beat();
    @(negedge clk);
    status_addr = BASE; status_writedata = 32'h1; status_write = 1;
    in_valid = 1; in_data = rand_beat();
    @(negedge clk);
    status_write = 0; in_data = b; beats.push_back(b);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    bus_write(BASE, 32'h0);
    bus_write(BASE, 32'h1);
    model_capture(0);
    exp_r = '{32'h1, 32'h2, 32'(exp_ptr), 32'(exp_count), 32'(exp_drop + 1)};
    for (int off = 0; off < 5; off++) begin
      bus_read(BASE | 30'(off), d, lat, np);
      total++;
      if (d !== exp_r[off]) begin bad++; $display("FAIL armdrop_reg%0d: got %h want %h", off, d, exp_r[off]); end
    end
  endtask

  task automatic test_clear_arm();
    logic [31:0] d; int lat, np;
    bus_write(BASE, 32'h4);
    beats.delete();
    bus_write(BASE, 32'h1);
    send_beats(3);
    model_capture(0);
    bus_write(BASE, 32'h5);
    for (int off = 1; off < 5; off++) begin
      bus_read(BASE | 30'(off), d, lat, np);
      total++;
      if (d !== 32'd0) begin bad++; $display("FAIL clear_arm_reg%0d: got %h want 0", off, d); end
    end
  endtask

  task automatic test_random();
    logic [31:0] d; int lat, np, n, s;
    bit wrap;
    logic [31:0] exp_r [5];
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 20);
      wrap = 1'($urandom_range(0, 1));
      bus_write(BASE, 32'h4);
      beats.delete();
      bus_write(BASE, wrap ? 32'h3 : 32'h1);
      send_beats(n);
      bus_write(BASE, wrap ? 32'h2 : 32'h0);
      model_capture(wrap);
      exp_r = '{wrap ? 32'h2 : 32'h0, {28'd0, exp_full, exp_wrapped, 2'd2}, 32'(exp_ptr), 32'(exp_count), 32'(exp_drop)};
      for (int off = 0; off < 5; off++) begin
        bus_read(BASE | 30'(off), d, lat, np);
        total++;
        if (d !== exp_r[off]) begin bad++; $display("FAIL rand%0d_reg%0d n=%0d wrap=%0d: got %h want %h", it, off, n, wrap, d, exp_r[off]); end
      end
      for (int w = 0; w < DEPTH; w++) begin
        if (mem_known[w]) begin
          s = $urandom_range(0, NW - 1);
          bus_read(mem_addr(w, s), d, lat, np);
          total++;
          if (d !== mem_m[w][s]) begin bad++; $display("FAIL rand%0d_mem w%0d s%0d: got %h want %h", it, w, s, d, mem_m[w][s]); end
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; int lat, np, pulses;
    @(negedge clk);
    status_addr = BASE | 30'h3; status_read = 1;
    @(negedge clk);
    status_read = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (status_readdata_valid) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL abort_pulse: got %0d pulses want 0", pulses); end
    for (int off = 0; off < 7; off++) begin
      bus_read(BASE | 30'(off), d, lat, np);
      total++;
      if (d !== 32'd0) begin bad++; $display("FAIL abort_reg%0d: got %h want 0", off, d); end
    end
  endtask

  task automatic test_tstamp();
    logic [31:0] d, e_start, e_stop; int lat, np;
    bus_write(BASE, 32'h4);
`ifdef RULEID_CAPTURE_TSTAMP_EN
    @(negedge clk);
    status_addr = BASE; status_writedata = 32'h1; status_write = 1;
    e_start = cyc + 1;
    @(negedge clk);
    status_write = 0;
    repeat (($urandom_range(3, 40))) @(negedge clk);
    status_addr = BASE; status_writedata = 32'h0; status_write = 1;
    e_stop = cyc + 1;
    @(negedge clk);
    status_write = 0;
`else
    bus_write(BASE, 32'h1);
    repeat (5) @(negedge clk);
    bus_write(BASE, 32'h0);
    e_start = 0;
    e_stop = 0;
`endif
    bus_read(BASE | 30'h5, d, lat, np);
    total++;
    if (d !== e_start) begin bad++; $display("FAIL start_ts: got %h want %h", d, e_start); end
    bus_read(BASE | 30'h6, d, lat, np);
    total++;
    if (d !== e_stop) begin bad++; $display("FAIL stop_ts: got %h want %h", d, e_stop); end
  endtask

  initial begin
    clk = 0; rst_n = 0; in_valid = 0; in_data = '0;
    status_addr = '0; status_read = 0; status_write = 0; status_writedata = '0;
    total = 0; bad = 0;
    for (int w = 0; w < DEPTH; w++) mem_known[w] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    test_reset();
    test_select();
    test_oneshot();
    test_read_latency();
    test_wrap();
    test_back_to_back();
    test_ro_writes();
    test_arm_drop();
    test_clear_arm();
    test_random();
    test_reset_abort();
    test_tstamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
